// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM port arbiter and its palette file.
package vram_arb_pkg;

    localparam int VRAM_DEPTH  = 2048;
    localparam int PAL_ENTRIES = 8;
    localparam int PAL_SEL_BIT = 11;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic [11:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } axi_req_t;

    // Merge new data into an old word, one byte per strobe bit.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                result[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/palette_regfile.sv
// 8x32 palette register file with bytewise write strobes, one write port,
// one combinational read port and the whole file exported for the colour mapper.
module palette_regfile
    import vram_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_idx,
    input  logic [3:0]  wr_strb,
    input  logic [31:0] wr_data,
    input  logic [2:0]  rd_idx,
    output logic [31:0] rd_data,
    output logic [31:0] entries [PAL_ENTRIES]
);

    // Entries clear on reset; a write lands the cycle after it is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else if (wr_en) begin
            entries[wr_idx] <= apply_strb(entries[wr_idx], wr_data, wr_strb);
        end
    end

    assign rd_data = entries[rd_idx];

endmodule

// File: rtl/vram_port_arbiter.sv
// Arbitrates one single-port VRAM between display fetch (priority) and AXI
// register access; address bit 11 selects the internal palette file instead.
// Optional build macro: VRAM_ARB_STARVE_GUARD_EN forces an AXI grant after
// STARVE_LIMIT consecutive blocked cycles.
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int VRAM_AW      = 11,
    parameter int STARVE_LIMIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               disp_req,
    input  logic [VRAM_AW-1:0] disp_addr,
    output logic               disp_gnt,
    output logic               disp_rvalid,
    output logic [31:0]        disp_rdata,
    input  logic               axi_valid,
    output logic               axi_ready,
    input  logic [ADDR_W-1:0]  axi_addr,
    input  logic               axi_we,
    input  logic [3:0]         axi_strb,
    input  logic [31:0]        axi_wdata,
    output logic               axi_rvalid,
    input  logic               axi_rready,
    output logic [31:0]        axi_rdata,
    output logic               mem_en,
    output logic [3:0]         mem_we,
    output logic [VRAM_AW-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    output logic [31:0]        palette [PAL_ENTRIES]
);

    arb_state_t  state;
    axi_req_t    req;
    logic        pal_sel;
    logic        accept;
    logic        starve_force;
    logic        pal_wr;
    logic [31:0] pal_rdata;

    assign req     = '{addr: axi_addr, we: axi_we, strb: axi_strb, wdata: axi_wdata};
    assign pal_sel = req.addr[PAL_SEL_BIT];

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    assign starve_force = (state == IDLE) && axi_valid && !pal_sel &&
                          (starve_cnt == CW'(STARVE_LIMIT));

    // Count consecutive blocked AXI VRAM cycles, saturating at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (accept || !(axi_valid && !pal_sel)) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    // Display has absolute priority; the starvation limit plays no role here.
    logic unused_starve_limit;
    assign unused_starve_limit = |STARVE_LIMIT;
    assign starve_force        = 1'b0;
`endif

    assign disp_gnt  = disp_req && !starve_force;
    assign axi_ready = axi_valid && (state == IDLE) && (pal_sel || !disp_gnt);
    assign accept    = axi_ready;
    assign pal_wr    = accept && pal_sel && req.we;

    // Display data comes straight off the RAM output in the cycle after its grant.
    assign disp_rdata = mem_rdata;

    // Steer the VRAM port: display first, then an accepted AXI VRAM access.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (disp_gnt) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end else if (accept && !pal_sel) begin
            mem_en    = 1'b1;
            mem_we    = req.we ? req.strb : 4'b0000;
            mem_addr  = req.addr[VRAM_AW-1:0];
            mem_wdata = req.wdata;
        end
    end

    // Display read-valid is the grant delayed by the RAM latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_rvalid <= 1'b0;
        end else begin
            disp_rvalid <= disp_gnt;
        end
    end

    // AXI read sequencing: VRAM reads wait one cycle for RAM data, palette reads
    // capture at accept; the response is held until the master takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            axi_rvalid <= 1'b0;
            axi_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && !req.we) begin
                        if (pal_sel) begin
                            axi_rdata  <= pal_rdata;
                            axi_rvalid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    axi_rdata  <= mem_rdata;
                    axi_rvalid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (axi_rready) begin
                        axi_rvalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    axi_rvalid <= 1'b0;
                end
            endcase
        end
    end

    palette_regfile u_palette (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (pal_wr),
        .wr_idx  (req.addr[2:0]),
        .wr_strb (req.strb),
        .wr_data (req.wdata),
        .rd_idx  (req.addr[2:0]),
        .rd_data (pal_rdata),
        .entries (palette)
    );

endmodule
